// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared data-bus transfer size and type encodings
package bus_pkg;

    localparam logic [1:0] TSIZE_BYTE  = 2'd0;
    localparam logic [1:0] TSIZE_HALF  = 2'd1;
    localparam logic [1:0] TSIZE_WORD  = 2'd2;

    localparam logic       TTYPE_READ  = 1'b0;
    localparam logic       TTYPE_WRITE = 1'b1;

endpackage

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - gpio_slave register offsets, FSM states and decode helpers
package gpio_pkg;

    import bus_pkg::*;

    localparam logic [7:0] OFF_DATA_IN  = 8'h00;
    localparam logic [7:0] OFF_DATA_OUT = 8'h04;
    localparam logic [7:0] OFF_DIR      = 8'h08;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
    localparam logic [7:0] OFF_IRQ_PEND = 8'h10;
    localparam logic [7:0] OFF_IRQ_EDGE = 8'h14;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        REG_DATA_IN,
        REG_DATA_OUT,
        REG_DIR,
        REG_IRQ_EN,
        REG_IRQ_PEND,
        REG_IRQ_EDGE,
        REG_NONE
    } reg_idx_t;

    // Map the low address byte to a register; anything else is unmapped.
    // Byte/half accesses inside a register resolve to that register.
    function automatic reg_idx_t decode_reg(input logic [7:0] off);
        reg_idx_t r;
        case ({off[7:2], 2'b00})
            OFF_DATA_IN:  r = REG_DATA_IN;
            OFF_DATA_OUT: r = REG_DATA_OUT;
            OFF_DIR:      r = REG_DIR;
            OFF_IRQ_EN:   r = REG_IRQ_EN;
            OFF_IRQ_PEND: r = REG_IRQ_PEND;
            OFF_IRQ_EDGE: r = REG_IRQ_EDGE;
            default:      r = REG_NONE;
        endcase
        return r;
    endfunction

    // Byte lanes touched by an access; all-zero means the access is misaligned
    // (or uses a reserved size) and must be rejected.
    function automatic logic [3:0] byte_lanes(input logic [1:0] tsize,
                                              input logic [1:0] low);
        logic [3:0] l;
        case (tsize)
            TSIZE_BYTE: l = 4'b0001 << low;
            TSIZE_HALF: l = low[0] ? 4'b0000 : (low[1] ? 4'b1100 : 4'b0011);
            TSIZE_WORD: l = (low == 2'b00) ? 4'b1111 : 4'b0000;
            default:    l = 4'b0000;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/slave_bus_if.sv
// rtl/slave_bus_if.sv - data-bus slave port bundle
interface slave_bus_if;

    logic        ss;
    logic        bstart;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  tsize;
    logic        ttype;
    logic [31:0] rdata;
    logic        bdone;
    logic        berror;

    modport slave (
        input  ss, bstart, addr, wdata, tsize, ttype,
        output rdata, bdone, berror
    );

    modport master (
        output ss, bstart, addr, wdata, tsize, ttype,
        input  rdata, bdone, berror
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - per-pin input synchronizer with polarity-selectable edge detect
module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    input  logic polarity,
    output logic sync_val,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Metastability chain; the last stage is the architecturally visible value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin_in};
        end
    end

    // One-cycle-delayed copy of the synchronized value for edge comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= sync_val;
        end
    end

    assign sync_val   = chain[SYNC_STAGES-1];
    // polarity 1 selects rising edges, 0 selects falling edges.
    assign edge_pulse = polarity ? (sync_val & ~prev) : (~sync_val & prev);

endmodule

// File: rtl/gpio_slave.sv
// rtl/gpio_slave.sv - memory-mapped GPIO peripheral with edge-latched interrupts
module gpio_slave
    import gpio_pkg::*;
    import bus_pkg::*;
#(
    parameter int N_GPIO      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    slave_bus_if.slave        bus,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oe,
    output logic              irq
);

    state_t            state;
    state_t            state_nxt;
    logic              bdone_c;

    logic [N_GPIO-1:0] data_out_q;
    logic [N_GPIO-1:0] dir_q;
    logic [N_GPIO-1:0] irq_en_q;
    logic [N_GPIO-1:0] irq_pend_q;
    logic [N_GPIO-1:0] irq_edge_q;
    logic [N_GPIO-1:0] data_in;
    logic [N_GPIO-1:0] edge_det;

    logic [31:0]       rdata_q;
    logic              berror_q;

    logic              start;
    reg_idx_t          reg_sel;
    logic              mapped;
    logic [3:0]        lanes;
    logic              aligned;
    logic [31:0]       lane_mask;
    logic [N_GPIO-1:0] wmask;
    logic [N_GPIO-1:0] wval;
    logic              wr_ok;
    logic              wr_out;
    logic              wr_dir;
    logic              wr_en;
    logic              wr_edge;
    logic              wr_pend;
    logic [N_GPIO-1:0] pend_clr;
    logic [31:0]       rd_word;
    logic              unused_bits;

    // Synchronizer and edge detector for every pin, outputs included.
    for (genvar i = 0; i < N_GPIO; i++) begin : g_pin
        gpio_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk        (clk),
            .rst_n      (rst_n),
            .pin_in     (gpio_in[i]),
            .polarity   (irq_edge_q[i]),
            .sync_val   (data_in[i]),
            .edge_pulse (edge_det[i])
        );
    end

    // Address/size decode and write-enable generation for the accepted transaction.
    always_comb begin
        start     = (state == ST_IDLE) && bus.ss && bus.bstart;
        reg_sel   = decode_reg(bus.addr[7:0]);
        mapped    = (reg_sel != REG_NONE);
        lanes     = byte_lanes(bus.tsize, bus.addr[1:0]);
        aligned   = (lanes != 4'b0000);
        lane_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
        wmask     = lane_mask[N_GPIO-1:0];
        wval      = bus.wdata[N_GPIO-1:0];
        wr_ok     = start && (bus.ttype == TTYPE_WRITE) && aligned;
        wr_out    = wr_ok && (reg_sel == REG_DATA_OUT);
        wr_dir    = wr_ok && (reg_sel == REG_DIR);
        wr_en     = wr_ok && (reg_sel == REG_IRQ_EN);
        wr_edge   = wr_ok && (reg_sel == REG_IRQ_EDGE);
        wr_pend   = wr_ok && (reg_sel == REG_IRQ_PEND);
        pend_clr  = wr_pend ? (wval & wmask) : '0;
    end

    // Full-register read mux; unmapped offsets read as zero.
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_DATA_IN:  rd_word[N_GPIO-1:0] = data_in;
            REG_DATA_OUT: rd_word[N_GPIO-1:0] = data_out_q;
            REG_DIR:      rd_word[N_GPIO-1:0] = dir_q;
            REG_IRQ_EN:   rd_word[N_GPIO-1:0] = irq_en_q;
            REG_IRQ_PEND: rd_word[N_GPIO-1:0] = irq_pend_q;
            REG_IRQ_EDGE: rd_word[N_GPIO-1:0] = irq_edge_q;
            default:      rd_word = '0;
        endcase
    end

    // Read-write configuration registers with byte-lane merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_edge_q <= '0;
        end else begin
            if (wr_out)  data_out_q <= (data_out_q & ~wmask) | (wval & wmask);
            if (wr_dir)  dir_q      <= (dir_q      & ~wmask) | (wval & wmask);
            if (wr_en)   irq_en_q   <= (irq_en_q   & ~wmask) | (wval & wmask);
            if (wr_edge) irq_edge_q <= (irq_edge_q & ~wmask) | (wval & wmask);
        end
    end

    // Pending bits: clear is applied first so a coincident edge keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pend_q <= '0;
        end else begin
            irq_pend_q <= (irq_pend_q & ~pend_clr) | edge_det;
        end
    end

    // Response data/error are captured with the request and held only for the bdone cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            berror_q <= 1'b0;
        end else if (start) begin
            rdata_q  <= (bus.ttype == TTYPE_READ) ? rd_word : '0;
            berror_q <= !mapped || !aligned;
        end else begin
            rdata_q  <= '0;
            berror_q <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and bdone; bstart is not looked at while responding.
    always_comb begin
        state_nxt = state;
        bdone_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.ss && bus.bstart) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bdone_c   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.bdone  = bdone_c;
    assign bus.rdata  = rdata_q;
    assign bus.berror = berror_q;

    assign gpio_out   = data_out_q;
    assign gpio_oe    = dir_q;
    assign irq        = |(irq_pend_q & irq_en_q);

    // Address bits above the register map alias, and wide data/lane bits beyond N_GPIO are dropped.
    assign unused_bits = &{1'b0, bus.addr[31:8], bus.wdata, lane_mask};

endmodule
